ram_program_loader: RTL
=======================

# ram_program_loader

Sequential loader that sits directly upstream of `random_access_memory` and drives its manual-programming inputs. On a `start` pulse it writes a compile-time program image into RAM, one word per address, from address 0 upward. It replaces hand-toggling of the address and program switches at bring-up, and while `busy` is high the CPU is held off the bus. With the optional read-back check compiled in, each word is re-read over the bus and compared against the image.

## Interface
Parameters:
- `WORDS`, 16: number of words loaded, legal range 1..16; the loader writes addresses 0..WORDS-1.
- `PROGRAM_IMAGE`, 128'h0: the image; the word for address i is `PROGRAM_IMAGE[8*i+7:8*i]`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a load; sampled only in IDLE or DONE.
- `busy` output 1: high from the cycle after `start` is accepted until the load completes.
- `done` output 1: high in DONE, held until the next accepted `start` or `rst`.
- `manual_mode` output 1: to RAM; high while `busy`.
- `manual_read` output 1: to RAM; one-cycle write strobe per word.
- `address` output 4: to RAM; the current word address.
- `program_switches` output 8: to RAM; the image word for `address`.
- `ram_write_to_bus` output 1: to RAM `write_to_bus`; high only in the CHECK state (only when `LOADER_VERIFY_EN` is defined).
- `bus` input 8: read-only tap of the shared bus. The loader never drives it.
- `error` output 1: sticky mismatch flag (only when `LOADER_VERIFY_EN` is defined).
- `fail_addr` output 4: address of the first mismatch (only when `LOADER_VERIFY_EN` is defined).

## Operation
- RAM contract: RAM writes `program_switches` into `address` on a rising edge where `manual_mode`=1 and `manual_read`=1. With `write_to_bus`=1, RAM drives `bus` with the contents of `address` combinationally.
- FSM states: IDLE, SETUP, WRITE, CHECK (only when `LOADER_VERIFY_EN` is defined), DONE.
- IDLE / DONE:
  - all RAM-facing outputs are 0;
  - `start`=1 clears the address counter to 0, clears `done` (and `error`/`fail_addr` when compiled in), then goes to SETUP.
- SETUP:
  - `manual_mode`=1, `manual_read`=0;
  - `address` and `program_switches` are presented one cycle ahead of the strobe;
  - next state is WRITE.
- WRITE:
  - `manual_read`=1; `address` and `program_switches` are unchanged from SETUP;
  - next state is CHECK if compiled in, otherwise "advance".
- CHECK:
  - `manual_read`=0, `ram_write_to_bus`=1;
  - `bus` is compared with the image word on the edge that leaves CHECK;
  - on mismatch: `error` is set, `fail_addr` is set to `address`, and the FSM goes to DONE, aborting the remaining words;
  - on match: "advance".
- Advance:
  - if `address` == WORDS-1, go to DONE;
  - otherwise increment `address` and go to SETUP.
- The address counter is 4 bits. WORDS=16 ends at address 15 and never wraps to 0.
- `start` asserted in SETUP, WRITE or CHECK is ignored; it is not queued.
- `rst` in any state:
  - FSM returns to IDLE at the next edge;
  - the address counter and every output go to 0;
  - RAM contents already written are left as they are (partial load);
  - reset has priority over a simultaneous `start`.
- Reset value of every output is 0.

## Timing
- If `start` is sampled high on edge E0, the FSM is in SETUP for address 0 in the cycle after E0, and `busy` goes high after E0.
- Without `LOADER_VERIFY_EN`:
  - 2 cycles per word;
  - `done` rises 2*WORDS cycles after E0, i.e. 32 cycles for WORDS=16.
- With `LOADER_VERIFY_EN`:
  - 3 cycles per word;
  - `done` rises 3*WORDS cycles after E0 on a clean load;
  - on a mismatch at word k, `done` rises 3*(k+1) cycles after E0.
- `busy` and `done` are never high together. `busy` falls on the same edge that `done` rises.
- `manual_read` is high for exactly one cycle per word, and never in the same cycle as `ram_write_to_bus`.

## Configuration
- Macro: `LOADER_VERIFY_EN`.
- Defined: the CHECK state, `ram_write_to_bus`, `error` and `fail_addr` exist, and every word is read back and compared.
- Undefined: those states and ports are removed. The enclosing top ties RAM `write_to_bus` low, and there is no read-back.

## Test plan
- Reset: assert `rst` for 2 cycles → every output is 0 and the FSM is in IDLE; a simultaneous `start` is ignored.
- Full load, WORDS=16, PROGRAM_IMAGE with word i = 8'hA0+i:
  - pulse `start` → 16 `manual_read` strobes at addresses 0..15 with data 8'hA0..8'hAF;
  - `done` rises 32 cycles after the start edge (48 with the macro defined);
  - a RAM model then reads back 8'hA0..8'hAF.
- Partial load, WORDS=4:
  - pulse `start` → writes only addresses 0..3, and `done` rises after 8 cycles;
  - RAM addresses 4..15 are unchanged.
- Start while busy: extra `start` pulses at cycles 3 and 10 → the strobe sequence and `done` timing are identical to the full-load case.
- Reset mid-load: `rst` during WRITE of address 5 → IDLE on the next edge with all outputs 0; RAM addresses 0..5 hold image data, 6..15 are untouched.
- Verify (macro defined): the RAM model corrupts address 7 to 8'h00 → `error`=1, `fail_addr`=7, and `done` rises 24 cycles after the start edge with no further strobes.

Source files
------------

// File: rtl/ram_program_loader.sv
// ram_program_loader
// -----------------------------------------------------------------------------
// Writes a compile-time program image into random_access_memory through its
// manual-programming inputs. The load starts on a `start` pulse and writes one
// word per address, beginning at address 0 and ending at WORDS-1. While `busy`
// is high the CPU is held off the bus.
//
// Optional feature macro: LOADER_VERIFY_EN. When it is defined, a CHECK state
// follows each write. In CHECK the word is read back over `bus` and compared
// with the image. The first mismatch aborts the load and latches `error` and
// `fail_addr`.
//
// Parameters
//   WORDS         number of words loaded (1..16)
//   PROGRAM_IMAGE word i is PROGRAM_IMAGE[8*i+7:8*i]
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   start             load request, accepted only in IDLE or DONE
//   busy              load in progress
//   done              load finished, held until the next accepted start
//   manual_mode       RAM manual mode, high while busy
//   manual_read       RAM write strobe, one cycle per word
//   address           RAM word address
//   program_switches  RAM write data (image word for address)
//   ram_write_to_bus  RAM read-back enable, CHECK state only (LOADER_VERIFY_EN)
//   error             sticky read-back mismatch flag (LOADER_VERIFY_EN)
//   fail_addr         address of the first mismatch (LOADER_VERIFY_EN)
//   bus               read-only tap of the shared bus
// -----------------------------------------------------------------------------
module ram_program_loader #(
    parameter int           WORDS         = 16,
    parameter logic [127:0] PROGRAM_IMAGE = 128'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       manual_mode,
    output logic       manual_read,
    output logic [3:0] address,
    output logic [7:0] program_switches,
`ifdef LOADER_VERIFY_EN
    output logic       ram_write_to_bus,
    output logic       error,
    output logic [3:0] fail_addr,
`endif
    input  logic [7:0] bus
);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd4
    } state_t;
`endif

    localparam logic [3:0] LAST_ADDR = 4'(WORDS - 1);

    // Image word stored at address a.
    function automatic logic [7:0] image_word(input logic [3:0] a);
        return PROGRAM_IMAGE[{a, 3'b000} +: 8];
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] addr_r;
    logic [3:0] addr_nxt_s;
    logic       busy_nxt_s;
    logic       busy_r;
    logic       done_r;
    logic       manual_mode_r;
    logic       manual_read_r;
    logic [3:0] address_r;
    logic [7:0] program_switches_r;
`ifdef LOADER_VERIFY_EN
    logic       wtb_r;
    logic       error_r;
    logic       error_nxt_s;
    logic [3:0] fail_addr_r;
    logic [3:0] fail_addr_nxt_s;
`else
    // Without read-back the bus tap has no consumer.
    logic       bus_unused_s;
    assign bus_unused_s = ^bus;
`endif

    // Next-state, address counter and sticky error logic.
    always_comb begin
        state_nxt_s     = state_r;
        addr_nxt_s      = addr_r;
`ifdef LOADER_VERIFY_EN
        error_nxt_s     = error_r;
        fail_addr_nxt_s = fail_addr_r;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_nxt_s      = 4'd0;
`ifdef LOADER_VERIFY_EN
                    error_nxt_s     = 1'b0;
                    fail_addr_nxt_s = 4'd0;
`endif
                    state_nxt_s     = ST_SETUP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SETUP: begin
                state_nxt_s = ST_WRITE;
            end
`ifdef LOADER_VERIFY_EN
            ST_WRITE: begin
                state_nxt_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus != image_word(addr_r)) begin
                    // First mismatch aborts the remaining words.
                    error_nxt_s     = 1'b1;
                    fail_addr_nxt_s = addr_r;
                    state_nxt_s     = ST_DONE;
                end else if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    addr_nxt_s  = addr_r + 4'd1;
                    state_nxt_s = ST_SETUP;
                end
            end
`else
            ST_WRITE: begin
                // Stop at the last word so WORDS=16 never wraps to 0.
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    addr_nxt_s  = addr_r + 4'd1;
                    state_nxt_s = ST_SETUP;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Busy decode of the next state so that the outputs can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_SETUP, ST_WRITE: busy_nxt_s = 1'b1;
`ifdef LOADER_VERIFY_EN
            ST_CHECK:           busy_nxt_s = 1'b1;
`endif
            default:            busy_nxt_s = 1'b0;
        endcase
    end

    // State, counter and registered outputs. Outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            addr_r             <= 4'd0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            manual_mode_r      <= 1'b0;
            manual_read_r      <= 1'b0;
            address_r          <= 4'd0;
            program_switches_r <= 8'd0;
`ifdef LOADER_VERIFY_EN
            wtb_r              <= 1'b0;
            error_r            <= 1'b0;
            fail_addr_r        <= 4'd0;
`endif
        end else begin
            state_r            <= state_nxt_s;
            addr_r             <= addr_nxt_s;
            busy_r             <= busy_nxt_s;
            done_r             <= (state_nxt_s == ST_DONE);
            manual_mode_r      <= busy_nxt_s;
            manual_read_r      <= (state_nxt_s == ST_WRITE);
            address_r          <= busy_nxt_s ? addr_nxt_s : 4'd0;
            program_switches_r <= busy_nxt_s ? image_word(addr_nxt_s) : 8'd0;
`ifdef LOADER_VERIFY_EN
            wtb_r              <= (state_nxt_s == ST_CHECK);
            error_r            <= error_nxt_s;
            fail_addr_r        <= fail_addr_nxt_s;
`endif
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign manual_mode      = manual_mode_r;
    assign manual_read      = manual_read_r;
    assign address          = address_r;
    assign program_switches = program_switches_r;
`ifdef LOADER_VERIFY_EN
    assign ram_write_to_bus = wtb_r;
    assign error            = error_r;
    assign fail_addr        = fail_addr_r;
`endif

endmodule
